// File: rtl/arm_pkg.sv
// Shared definitions for the memory / write-back end of the ARM pipeline.
// Holds the datapath widths, the byte address where data memory begins,
// the stage FSM state type and the MEM/WB pipeline register bundle.
package arm_pkg;

  localparam int WIDTH     = 32;
  localparam int REG_IDX_W = 4;
  localparam int MEM_BASE  = 1024;

  typedef enum logic {
    IDLE,
    BUSY
  } stage_state_t;

  // Contents of the MEM/WB pipeline register. An all-zero value is a bubble.
  typedef struct packed {
    logic                 wb_en;
    logic                 mem_r;
    logic [REG_IDX_W-1:0] dest;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     mem_data;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus between the EXE/MEM register (upstream) and the MEM/WB stage.
// Upstream drives the instruction fields; the stage returns ready (used
// upstream as freeze) and the write-back triple for the register file.
//   master : upstream / ID-stage side
//   slave  : mem_wb_stage side
interface mem_wb_stage_if #(
  parameter int WIDTH = 32
);

  logic                 WB_EN;
  logic                 MEM_R_EN;
  logic                 MEM_W_EN;
  logic [WIDTH-1:0]     ALU_res;
  logic [WIDTH-1:0]     Val_Rm;
  logic [3:0]           Dest;
  logic                 ready;
  logic                 WB_WB_en;
  logic [3:0]           WB_Dest;
  logic [WIDTH-1:0]     WB_Value;

  modport master (
    output WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm, Dest,
    input  ready, WB_WB_en, WB_Dest, WB_Value
  );

  modport slave (
    input  WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm, Dest,
    output ready, WB_WB_en, WB_Dest, WB_Value
  );

endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory for the MEM stage.
// Synchronous write, combinational read, no reset (contents are undefined
// until written).
//   clk   : clock
//   we    : write enable, word written on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : read data for addr (combinational)
module data_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; a write lands on the edge that ends the access.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory and write-back end of the ARM pipeline.
// Accepts an instruction from EXE/MEM, performs a multi-cycle data-memory
// access for LDR/STR while holding ready low, latches the result into the
// MEM/WB register and drives the write-back triple to the register file.
//   clk : pipeline clock
//   rst : synchronous, active-high reset (aborts any access in flight)
//   bus : instruction inputs, ready, and WB_WB_en/WB_Dest/WB_Value outputs
module mem_wb_stage
  import arm_pkg::*;
#(
  parameter int WIDTH       = arm_pkg::WIDTH,
  parameter int MEM_DEPTH   = 64,
  parameter int MEM_BASE    = arm_pkg::MEM_BASE,
  parameter int MEM_LATENCY = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  stage_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req;
  logic              ready;
  logic              mem_we;
  logic              mem_r_sel;
  logic [ADDR_W-1:0] word_idx;
  logic [WIDTH-1:0]  mem_rdata;
  mem_wb_t           mem_wb_q, mem_wb_d;

  assign req = bus.MEM_R_EN | bus.MEM_W_EN;

  // A simultaneous read and write request is treated as a store, so the
  // write-back value falls back to the ALU result.
  assign mem_r_sel = bus.MEM_R_EN & ~bus.MEM_W_EN;

  // Offset from the memory base, in words; high bits are dropped so any
  // address outside the window wraps into it.
  assign word_idx = ADDR_W'((bus.ALU_res - WIDTH'(MEM_BASE)) >> 2);

  data_memory #(
    .WIDTH (WIDTH),
    .DEPTH (MEM_DEPTH)
  ) u_data_memory (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (bus.Val_Rm),
    .rdata (mem_rdata)
  );

  // Access sequencer: the presentation cycle plus MEM_LATENCY-1 counted
  // BUSY cycles stall upstream, then one ready cycle completes the access.
  // Reset forces ready high and blocks the pending store.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          ready   = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          ready = 1'b0;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we  = bus.MEM_W_EN;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      ready  = 1'b1;
      mem_we = 1'b0;
    end
  end

  // Next MEM/WB content: the instruction when the stage advances, otherwise
  // a bubble so nothing is written back during a stall.
  always_comb begin
    mem_wb_d = '0;
    if (ready) begin
      mem_wb_d.wb_en    = bus.WB_EN;
      mem_wb_d.mem_r    = mem_r_sel;
      mem_wb_d.dest     = bus.Dest;
      mem_wb_d.alu_res  = bus.ALU_res;
      mem_wb_d.mem_data = mem_rdata;
    end
  end

  // State, latency counter and MEM/WB register all clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.ready    = ready;
  assign bus.WB_WB_en = mem_wb_q.wb_en;
  assign bus.WB_Dest  = mem_wb_q.dest;
  assign bus.WB_Value = mem_wb_q.mem_r ? mem_wb_q.mem_data : mem_wb_q.alu_res;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage.
// A driver issues instructions and pushes the expected write-back into a
// scoreboard queue using a plain word-array model of data memory; a monitor
// pops and compares whenever the stage writes back. A second instance built
// with MEM_LATENCY=1 gets a short directed check.
module tb_mem_wb_stage;

  localparam int LAT = 4;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] value;
  } exp_t;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  exp_t        sb_q[$];
  logic [31:0] model_mem [64];

  mem_wb_stage_if #(.WIDTH(32)) bus1 ();
  mem_wb_stage_if #(.WIDTH(32)) bus2 ();

  mem_wb_stage #(
    .WIDTH       (32),
    .MEM_DEPTH   (64),
    .MEM_BASE    (1024),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  mem_wb_stage #(
    .WIDTH       (32),
    .MEM_DEPTH   (64),
    .MEM_BASE    (1024),
    .MEM_LATENCY (1)
  ) dut_lat1 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word slot an address lands in: byte offset from 1024, in words, modulo 64.
  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 32'd4) % 32'd64);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nop1();
    bus1.WB_EN    = 1'b0;
    bus1.MEM_R_EN = 1'b0;
    bus1.MEM_W_EN = 1'b0;
    bus1.ALU_res  = '0;
    bus1.Val_Rm   = '0;
    bus1.Dest     = '0;
  endtask

  task automatic nop2();
    bus2.WB_EN    = 1'b0;
    bus2.MEM_R_EN = 1'b0;
    bus2.MEM_W_EN = 1'b0;
    bus2.ALU_res  = '0;
    bus2.Val_Rm   = '0;
    bus2.Dest     = '0;
  endtask

  // Present one instruction, hold it until the stage takes it, check the
  // number of stalled cycles and record the expected write-back.
  task automatic applyStimulus(input logic wb, input logic rd, input logic wr,
                               input logic [31:0] alu, input logic [31:0] val,
                               input logic [3:0] dst);
    int   lows;
    bit   done;
    logic r;
    exp_t e;
    bus1.WB_EN    = wb;
    bus1.MEM_R_EN = rd;
    bus1.MEM_W_EN = wr;
    bus1.ALU_res  = alu;
    bus1.Val_Rm   = val;
    bus1.Dest     = dst;
    lows = 0;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      r = bus1.ready;
      @(posedge clk);
      if (r === 1'b1) done = 1'b1;
      else lows++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL timeout: ready stayed low for %0d cycles, want %0d", lows, LAT);
    end else begin
      if (wb) begin
        e.dest  = dst;
        e.value = (rd && !wr) ? model_mem[word_of(alu)] : alu;
        sb_q.push_back(e);
      end
      if (wr) model_mem[word_of(alu)] = val;
    end
    checkOutput("stall_cycles", lows, (rd || wr) ? LAT : 0);
    #1 nop1();
  endtask

  // Monitor: compares every write-back against the scoreboard, and checks
  // that stalls and reset leave a bubble in MEM/WB.
  initial begin
    logic prev_ready;
    logic prev_rst;
    exp_t e;
    prev_ready = 1'b1;
    prev_rst   = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        checkOutput("rst_wb_en", bus1.WB_WB_en, 0);
        checkOutput("rst_wb_dest", bus1.WB_Dest, 0);
        checkOutput("rst_wb_value", bus1.WB_Value, 0);
      end else if (prev_ready !== 1'b1) begin
        checkOutput("bubble_wb_en", bus1.WB_WB_en, 0);
      end else if (bus1.WB_WB_en === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_wb", bus1.WB_WB_en, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("wb_dest", bus1.WB_Dest, e.dest);
          checkOutput("wb_value", bus1.WB_Value, e.value);
        end
      end
      if (rst) checkOutput("ready_in_reset", bus1.ready, 1);
      prev_ready = bus1.ready;
      prev_rst   = rst;
    end
  end

  // Main sequence: directed scenarios, memory fill, randomized traffic,
  // then the MEM_LATENCY=1 instance.
  initial begin
    int          kind;
    logic        wb;
    logic [31:0] addr;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    nop1();
    nop2();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] non-memory op");
    applyStimulus(1, 0, 0, 32'h55, 32'h0, 4'd3);

    $display("[TB] store then load");
    applyStimulus(0, 0, 1, 32'd1032, 32'hDEADBEEF, 4'd0);
    applyStimulus(1, 1, 0, 32'd1032, 32'h0, 4'd5);

    $display("[TB] address wrap");
    applyStimulus(0, 0, 1, 32'd1024 + 32'd256, 32'h1234, 4'd0);
    applyStimulus(1, 1, 0, 32'd1024, 32'h0, 4'd9);

    $display("[TB] reset mid-access");
    applyStimulus(0, 0, 1, 32'd1040, 32'h0, 4'd0);
    bus1.MEM_W_EN = 1'b1;
    bus1.ALU_res  = 32'd1040;
    bus1.Val_Rm   = 32'hAAAA;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    nop1();
    applyStimulus(1, 0, 0, 32'hABC, 32'h0, 4'd2);
    applyStimulus(1, 1, 0, 32'd1040, 32'h0, 4'd4);

    $display("[TB] back-to-back loads then ALU op");
    applyStimulus(1, 1, 0, 32'd1032, 32'h0, 4'd6);
    applyStimulus(1, 1, 0, 32'd1040, 32'h0, 4'd7);
    applyStimulus(1, 0, 0, 32'h99, 32'h0, 4'd8);

    $display("[TB] filling memory");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 1, 32'd1024 + 32'(4 * i), $urandom, 4'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 7));
      wb   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if (kind < 3) begin
        applyStimulus(wb, 0, 0, $urandom, $urandom, 4'($urandom));
      end else if (kind < 5) begin
        applyStimulus(1, 1, 0, addr, $urandom, 4'($urandom));
      end else if (kind < 7) begin
        applyStimulus(wb, 0, 1, addr, $urandom, 4'($urandom));
      end else begin
        applyStimulus(wb, 1, 1, addr, $urandom, 4'($urandom));
      end
    end

    $display("[TB] MEM_LATENCY=1 instance");
    bus2.MEM_W_EN = 1'b1;
    bus2.ALU_res  = 32'd1028;
    bus2.Val_Rm   = 32'h77;
    @(negedge clk);
    checkOutput("lat1_store_ready_low", bus2.ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat1_store_ready_high", bus2.ready, 1);
    @(posedge clk);
    #1;
    nop2();
    bus2.WB_EN    = 1'b1;
    bus2.MEM_R_EN = 1'b1;
    bus2.ALU_res  = 32'd1028;
    bus2.Dest     = 4'd7;
    @(negedge clk);
    checkOutput("lat1_load_ready_c1", bus2.ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat1_load_ready_c2", bus2.ready, 1);
    checkOutput("lat1_wb_en_c2", bus2.WB_WB_en, 0);
    @(posedge clk);
    #1 nop2();
    @(negedge clk);
    checkOutput("lat1_wb_en_c3", bus2.WB_WB_en, 1);
    checkOutput("lat1_wb_dest_c3", bus2.WB_Dest, 7);
    checkOutput("lat1_wb_value_c3", bus2.WB_Value, 32'h77);
    checkOutput("lat1_ready_c3", bus2.ready, 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
